// File: rtl/coreriscv_axi4_resp_reorder_buf.sv
// rtl/coreriscv_axi4_resp_reorder_buf.sv - AXI4 bridge response reorder buffer
// Hands out tags from a ring of 2^TAG_W slots, stores out-of-order responses by
// tag and releases them in allocation order. Optional same-cycle head bypass is
// enabled by defining CORERISCV_AXI4_ROB_BYPASS_EN.
module coreriscv_axi4_resp_reorder_buf #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  output logic [TAG_W-1:0]  req_tag_o,
  input  logic              resp_valid_i,
  input  logic [TAG_W-1:0]  resp_tag_i,
  input  logic [DATA_W-1:0] resp_data_i,
  output logic              resp_ready_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [TAG_W-1:0]  out_tag_o,
  output logic [TAG_W:0]    outstanding_o,
  output logic              err_spurious_o
);

  localparam int DEPTH = 1 << TAG_W;
  localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(DEPTH);

  logic [TAG_W-1:0]  head_q, head_d;
  logic [TAG_W-1:0]  tail_q, tail_d;
  logic [TAG_W:0]    count_q, count_d;
  logic [DEPTH-1:0]  pending_q, pending_d;
  logic [DEPTH-1:0]  filled_q, filled_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              err_q;

  logic alloc;
  logic retire;
  logic accept;
  logic store;
  logic bypass;
  logic head_filled;

  assign req_ready_o    = (count_q != DEPTH_C);
  assign req_tag_o      = tail_q;
  assign resp_ready_o   = 1'b1;
  assign out_tag_o      = head_q;
  assign outstanding_o  = count_q;
  assign err_spurious_o = err_q;

  assign alloc       = req_valid_i & req_ready_o;
  assign head_filled = filled_q[head_q];

`ifdef CORERISCV_AXI4_ROB_BYPASS_EN
  assign bypass = ~filled_q[head_q] & pending_q[head_q] & resp_valid_i &
                  (resp_tag_i == head_q);
`else
  assign bypass = 1'b0;
`endif

  assign out_valid_o = head_filled | bypass;
  assign retire      = out_valid_o & out_ready_i;

  // A slot being allocated this cycle is not yet pending, so it is dropped too
  assign accept = resp_valid_i & pending_q[resp_tag_i] & ~filled_q[resp_tag_i] &
                  ~(alloc & (resp_tag_i == tail_q));
  // A bypassed response that retires immediately never touches storage
  assign store  = accept & ~(bypass & out_ready_i);

  // Released payload, zero whenever nothing is being presented
  always_comb begin
    out_data_o = '0;
    if (head_filled) begin
      out_data_o = mem_q[head_q];
    end else if (bypass) begin
      out_data_o = resp_data_i;
    end
  end

  // Next-state for pointers, occupancy and per-slot flags
  always_comb begin
    pending_d = pending_q;
    filled_d  = filled_q;
    head_d    = head_q;
    tail_d    = tail_q;
    if (retire) begin
      pending_d[head_q] = 1'b0;
      filled_d[head_q]  = 1'b0;
      head_d            = head_q + TAG_W'(1);
    end
    if (store) begin
      filled_d[resp_tag_i] = 1'b1;
    end
    if (alloc) begin
      pending_d[tail_q] = 1'b1;
      filled_d[tail_q]  = 1'b0;
      tail_d            = tail_q + TAG_W'(1);
    end
    count_d = count_q + (TAG_W+1)'(alloc) - (TAG_W+1)'(retire);
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      pending_q <= '0;
      filled_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      filled_q  <= filled_d;
      err_q     <= resp_valid_i & ~accept;
    end
  end

  // Payload storage, validity is tracked by filled_q so no reset is needed
  always_ff @(posedge clk) begin
    if (store) begin
      mem_q[resp_tag_i] <= resp_data_i;
    end
  end

endmodule

// File: doc/coreriscv_axi4_resp_reorder_buf.md
# coreriscv_axi4_resp_reorder_buf

Response reorder buffer for the AXI4 bridge. It assigns a tag to each outgoing request from a free-running ring of 2^TAG_W slots. Responses may return from the tag-matching queue stage out of order; the block stores each by tag and releases them strictly in allocation order. It sits directly downstream of the per-tag match/data queue and upstream of the core-side response port.

## Interface
- DATA_W, 32, response payload width
- TAG_W, 2, tag width; DEPTH = 2^TAG_W slots
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  request wants a tag
- req_ready  out  1  a slot is free; tag granted when req_valid & req_ready
- req_tag  out  TAG_W  tag granted this cycle (= tail pointer)
- resp_valid  in  1  response present
- resp_tag  in  TAG_W  tag of response
- resp_data  in  DATA_W  response payload
- resp_ready  out  1  tied 1; responses are never back-pressured
- out_valid  out  1  in-order response available
- out_ready  in  1  consumer accepts
- out_data  out  DATA_W  payload; forced 0 when out_valid=0
- out_tag  out  TAG_W  tag of released response (= head pointer)
- outstanding  out  TAG_W+1  allocated, not yet retired slots
- err_spurious  out  1  one-cycle pulse: response dropped

## Operation
- State: head, tail (TAG_W bits, wrap modulo DEPTH), count (TAG_W+1), pending[DEPTH], filled[DEPTH], data mem[DEPTH] (not reset).
- Allocate (req_valid & req_ready): pending[tail]=1, filled[tail]=0, tail++.
- req_ready = (count != DEPTH), from registered count only; a slot freed this cycle is not reusable until next cycle.
- Accept response (resp_valid): if pending[resp_tag]=1 and filled[resp_tag]=0, write mem[resp_tag]=resp_data, set filled. Otherwise drop and set err_spurious=1 the next cycle. Drop cases: tag not pending, tag already filled, tag allocated in the same cycle.
- Release: out_valid = filled[head]; out_data = mem[head]. On out_valid & out_ready: pending[head]=0, filled[head]=0, head++.
- count' = count + alloc - retire; alloc and retire in the same cycle leave count unchanged.
- Response to the head slot while it retires in the same cycle: the slot is already filled, so the response is spurious.
- Reset mid-operation clears all pointers and flags. In-flight responses after reset are treated as spurious.
- Outputs after reset: req_ready=1, req_tag=0, resp_ready=1, out_valid=0, out_data=0, out_tag=0, outstanding=0, err_spurious=0.

## Timing
- Tag grant: combinational; req_tag is valid in the handshake cycle.
- Response to out_valid: 1 cycle (registered filled) without bypass.
- Retire to req_ready rising (from full): 1 cycle.
- err_spurious: asserted the cycle after the offending resp_valid, for 1 cycle.
- Throughput: 1 allocation + 1 response + 1 release per cycle.

## Configuration
- CORERISCV_AXI4_ROB_BYPASS_EN defined: bypass is enabled when all of the following hold: filled[head]=0, pending[head]=1, resp_valid=1, resp_tag=head.
  - In that cycle: out_valid=1 and out_data=resp_data, combinationally (0-cycle latency).
  - If out_ready=1: retire directly; mem and filled are not written.
  - If out_ready=0: store as normal.
- Undefined: no combinational path resp_* -> out_*. Minimum latency is 1 cycle.

## Test plan
- Reset, then 4 allocations with resp idle -> req_tag 0,1,2,3. req_ready=0 after the 4th, outstanding=4, out_valid=0.
- Responses in order tag 2 (0xA2), 0 (0xA0), 3 (0xA3), 1 (0xA1), out_ready=1 -> out_data sequence 0xA0, 0xA1, 0xA2, 0xA3 with out_tag 0..3. Release timing:
  - 0xA0 one cycle after its response.
  - 0xA1..0xA3 on consecutive cycles after tag 1 arrives.
  - outstanding returns to 0.
- Full buffer, release head with req_valid=1 held -> req_ready rises the cycle after the retire. The next tag is 0 (wrap), and the new tag is not granted in the retire cycle.
- Response tag 1 while only tag 0 is allocated, then a duplicate response on tag 0 -> err_spurious pulses once for each. Payload stays at the first tag-0 data.
- out_ready=0 for 5 cycles with slot 0 filled -> out_valid and out_data held stable. Allocations continue until full.
- Bypass: macro defined, head empty, response on head tag 0x55 with out_ready=1 -> out_valid=1 and out_data=0x55 in the same cycle. Macro undefined -> the same data appears one cycle later.
